// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B.
// Zero-fills the RAM after reset (CLR_EN=1), then serves one transaction at a time.
module ram_arbiter #(
  parameter int unsigned N      = 8,
  parameter int unsigned SZ     = 32,
  parameter int unsigned RD_LAT = 1,
  parameter bit          CLR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_a,
  input  logic         req_b,
  input  logic         we_a,
  input  logic         we_b,
  input  logic [N-1:0] addr_a,
  input  logic [N-1:0] addr_b,
  input  logic [N-1:0] wdata_a,
  input  logic [N-1:0] wdata_b,
  output logic         gnt_a,
  output logic         gnt_b,
  output logic         ack_a,
  output logic         ack_b,
  output logic [N-1:0] rdata,
  output logic         err,
  output logic         busy,
  output logic [N-1:0] ram_iaddr,
  output logic [N-1:0] ram_i,
  output logic         ram_rw,
  input  logic [N-1:0] ram_o
);

  localparam int unsigned WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [N:0]   SZ_W    = (N+1)'(SZ);
  localparam logic [N-1:0] SZ_LAST = N'(SZ - 1);

  typedef enum logic [2:0] {CLEAR, IDLE, ACCESS, WAIT, RESP} state_t;

  state_t        state;
  logic          last_b;
  logic          owner_b;
  logic          lat_we;
  logic          lat_bad;
  logic [WW-1:0] wait_cnt;

  logic          pick;
  logic          pick_b;
  logic          win_we;
  logic [N-1:0]  win_addr;
  logic [N-1:0]  win_wdata;
  logic          win_bad;
  logic [N-1:0]  clr_next;

  always_comb begin
    pick      = req_a | req_b;
    // on a tie B wins only when A was the last winner
    pick_b    = req_b & (~req_a | ~last_b);
    win_we    = pick_b ? we_b    : we_a;
    win_addr  = pick_b ? addr_b  : addr_a;
    win_wdata = pick_b ? wdata_b : wdata_a;
    win_bad   = {1'b0, win_addr} >= SZ_W;
    // ram_rw is still 0 on the first CLEAR cycle, so it doubles as the "started" flag
    clr_next  = ram_rw ? ram_iaddr + N'(1) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= CLR_EN ? CLEAR : IDLE;
      busy      <= CLR_EN;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      ram_rw    <= 1'b0;
      ram_iaddr <= '0;
      ram_i     <= '0;
      last_b    <= 1'b1;
      owner_b   <= 1'b0;
      lat_we    <= 1'b0;
      lat_bad   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      case (state)
        CLEAR: begin
          ram_rw    <= 1'b1;
          ram_i     <= '0;
          ram_iaddr <= clr_next;
          // the last address is still presented during the first IDLE cycle
          if (clr_next == SZ_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          ram_rw <= 1'b0;
          if (pick) begin
            state   <= ACCESS;
            busy    <= 1'b1;
            gnt_a   <= ~pick_b;
            gnt_b   <= pick_b;
            last_b  <= pick_b;
            owner_b <= pick_b;
            lat_we  <= win_we;
            lat_bad <= win_bad;
            rdata   <= '0;
            err     <= 1'b0;
            if (!win_bad) begin
              ram_iaddr <= win_addr;
              ram_i     <= win_wdata;
              ram_rw    <= win_we;
            end
          end
        end
        ACCESS: begin
          ram_rw <= 1'b0;
          if (lat_bad || lat_we) begin
            state <= RESP;
            ack_a <= ~owner_b;
            ack_b <= owner_b;
            err   <= lat_bad;
          end else begin
            state    <= WAIT;
            wait_cnt <= WW'(RD_LAT - 1);
          end
        end
        WAIT: begin
          ram_rw <= 1'b0;
          if (wait_cnt == '0) begin
            rdata <= ram_o;
            state <= RESP;
            ack_a <= ~owner_b;
            ack_b <= owner_b;
          end else begin
            wait_cnt <= wait_cnt - WW'(1);
          end
        end
        RESP: begin
          ram_rw <= 1'b0;
          state  <= IDLE;
          busy   <= 1'b0;
          gnt_a  <= 1'b0;
          gnt_b  <= 1'b0;
          err    <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          ram_rw <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM (1-cycle read latency).
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, req_b, we_a, we_b;
  logic [7:0] addr_a, addr_b, wdata_a, wdata_b;
  logic       gnt_a, gnt_b, ack_a, ack_b, err, busy, ram_rw;
  logic [7:0] rdata, ram_iaddr, ram_i, ram_o;

  int checks = 0;
  int errors = 0;
  bit tb_last_b = 1'b1;

  logic [7:0] mem [0:255];

  ram_arbiter #(.N(8), .SZ(32), .RD_LAT(1), .CLR_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .ack_a(ack_a), .ack_b(ack_b),
    .rdata(rdata), .err(err), .busy(busy),
    .ram_iaddr(ram_iaddr), .ram_i(ram_i), .ram_rw(ram_rw), .ram_o(ram_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rw) mem[ram_iaddr] <= ram_i;
    ram_o <= mem[ram_iaddr];
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h5A;
    ram_o = 8'h00;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},   {30'd0, gnt_a, gnt_b}, 0);
    chk({tag, "_ack"},   {30'd0, ack_a, ack_b}, 0);
    chk({tag, "_rdata"}, 32'(rdata), 0);
    chk({tag, "_err"},   32'(err), 0);
    chk({tag, "_rw"},    32'(ram_rw), 0);
    chk({tag, "_iaddr"}, 32'(ram_iaddr), 0);
    chk({tag, "_ram_i"}, 32'(ram_i), 0);
    chk({tag, "_busy"},  32'(busy), 1);
  endtask

  // One transaction; starts and ends on a falling edge with the DUT in IDLE.
  task automatic txn(input bit is_b, input logic we, input logic [7:0] addr,
                     input logic [7:0] wd, output logic [7:0] rd, output logic er,
                     output int lat, output bit rw_seen);
    bit got = 1'b0;
    rd = 8'h00; er = 1'b0; lat = 0; rw_seen = 1'b0;
    if (is_b) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd; end
    else      begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd; end
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (ram_rw) rw_seen = 1'b1;
      chk("gnt_excl", 32'(gnt_a & gnt_b), 0);
      if (is_b ? ack_b : ack_a) begin
        got = 1'b1;
        lat = c;
        rd  = rdata;
        er  = err;
        chk("ack_other", 32'(is_b ? ack_a : ack_b), 0);
        chk("ack_own_gnt", 32'(is_b ? gnt_b : gnt_a), 1);
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("ack_seen", 32'(got), 1);
    tb_last_b = is_b;
    @(negedge clk);
    chk("ack_pulse", {30'd0, ack_a, ack_b}, 0);
    chk("gnt_drop", {30'd0, gnt_a, gnt_b}, 0);
  endtask

  typedef struct {
    bit         is_b;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [7:0] rd;
    logic       er;
    int         lat;
    bit         rw_seen;
    bit         order[4];
    int         nack;
    bit         first_b;

    vecs[0]  = '{1'b0, 1'b0, 8'h05, 8'h00, 8'h00, 1'b0, 3};
    vecs[1]  = '{1'b0, 1'b1, 8'h02, 8'hCA, 8'h00, 1'b0, 2};
    vecs[2]  = '{1'b0, 1'b0, 8'h02, 8'h00, 8'hCA, 1'b0, 3};
    vecs[3]  = '{1'b1, 1'b1, 8'h1F, 8'h77, 8'h00, 1'b0, 2};
    vecs[4]  = '{1'b0, 1'b0, 8'h1F, 8'h00, 8'h77, 1'b0, 3};
    vecs[5]  = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1, 2};
    vecs[6]  = '{1'b0, 1'b1, 8'h20, 8'h99, 8'h00, 1'b1, 2};
    vecs[7]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 2};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 3};
    vecs[9]  = '{1'b1, 1'b1, 8'h10, 8'h3C, 8'h00, 1'b0, 2};
    vecs[10] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h3C, 1'b0, 3};

    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
    reset = 1'b0;
    #12;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("clr_c0_busy", 32'(busy), 1);
    chk("clr_c0_rw", 32'(ram_rw), 0);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk("clr_rw", 32'(ram_rw), 1);
      chk("clr_iaddr", 32'(ram_iaddr), 32'(k - 1));
      chk("clr_ram_i", 32'(ram_i), 0);
      chk("clr_busy", 32'(busy), (k < 32) ? 1 : 0);
    end
    @(negedge clk);
    chk("clr_done_rw", 32'(ram_rw), 0);
    chk("clr_done_busy", 32'(busy), 0);

    for (int v = 0; v < 11; v++) begin
      txn(vecs[v].is_b, vecs[v].we, vecs[v].addr, vecs[v].wdata, rd, er, lat, rw_seen);
      chk($sformatf("v%0d_rdata", v), 32'(rd), 32'(vecs[v].exp_rd));
      chk($sformatf("v%0d_err", v), 32'(er), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
      chk($sformatf("v%0d_rw", v), 32'(rw_seen), 32'(vecs[v].we && !vecs[v].exp_err));
    end

    // both requesters held high: grants must alternate starting with the non-last winner
    first_b = ~tb_last_b;
    req_a = 1; we_a = 1; addr_a = 8'h03; wdata_a = 8'hFE;
    req_b = 1; we_b = 1; addr_b = 8'h04; wdata_b = 8'hED;
    nack = 0;
    for (int c = 0; c < 40 && nack < 4; c++) begin
      @(negedge clk);
      chk("rr_gnt_excl", 32'(gnt_a & gnt_b), 0);
      if (ack_a) begin chk("rr_ack_a_gnt", 32'(gnt_a), 1); order[nack] = 1'b0; nack++; end
      if (ack_b) begin chk("rr_ack_b_gnt", 32'(gnt_b), 1); order[nack] = 1'b1; nack++; end
    end
    req_a = 0; req_b = 0;
    chk("rr_ack_count", 32'(nack), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(first_b ^ i[0]));
    tb_last_b = 1'b1;
    @(negedge clk);
    txn(1'b0, 1'b0, 8'h03, 8'h00, rd, er, lat, rw_seen);
    chk("rb03_rdata", 32'(rd), 32'hFE);
    txn(1'b0, 1'b0, 8'h04, 8'h00, rd, er, lat, rw_seen);
    chk("rb04_rdata", 32'(rd), 32'hED);

    // reset asserted while a read sits in WAIT
    req_a = 1; we_a = 0; addr_a = 8'h03;
    @(negedge clk);
    chk("mid_gnt_a", 32'(gnt_a), 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("mid");
    req_a = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_ack", {30'd0, ack_a, ack_b}, 0);
    end
    reset = 1'b1;
    req_a = 1; we_a = 0; addr_a = 8'h02;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      chk("reclr_no_gnt", 32'(gnt_a), 0);
      chk("reclr_busy", 32'(busy), 1);
    end
    txn(1'b0, 1'b0, 8'h02, 8'h00, rd, er, lat, rw_seen);
    chk("reclr_rdata", 32'(rd), 32'h00);
    chk("reclr_err", 32'(er), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
